// File: rtl/prop_clk_pkg.sv
// Shared types for the Propeller-style clock controller: FSM states, CLKSEL codes,
// the clock-enable divisor table and the CLKSEL legality rule.
package prop_clk_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [2:0] SEL_RCFAST = 3'b000;
  localparam logic [2:0] SEL_RCSLOW = 3'b001;
  localparam logic [2:0] SEL_XIN    = 3'b010;
  localparam logic [2:0] SEL_PLL1X  = 3'b011;
  localparam logic [2:0] SEL_PLL2X  = 3'b100;
  localparam logic [2:0] SEL_PLL4X  = 3'b101;
  localparam logic [2:0] SEL_PLL8X  = 3'b110;
  localparam logic [2:0] SEL_PLL16X = 3'b111;

  localparam int DIV_W = 16;

  function automatic logic [DIV_W-1:0] sel_div(input logic [2:0] sel,
                                               input logic [DIV_W-1:0] slow_div);
    case (sel)
      SEL_RCFAST: return 16'd1;
      SEL_RCSLOW: return slow_div;
      SEL_XIN:    return 16'd16;
      SEL_PLL1X:  return 16'd16;
      SEL_PLL2X:  return 16'd8;
      SEL_PLL4X:  return 16'd4;
      SEL_PLL8X:  return 16'd2;
      default:    return 16'd1;
    endcase
  endfunction

  // RC sources are always available; crystal needs OSCENA, PLL modes need both.
  function automatic logic sel_legal(input logic [2:0] sel, input logic oscena,
                                     input logic pllena);
    if (sel == SEL_RCFAST || sel == SEL_RCSLOW) return 1'b1;
    if (sel == SEL_XIN) return oscena;
    return oscena & pllena;
  endfunction

endpackage

// File: rtl/prop_clk_ctrl_if.sv
// Core-facing signal bundle of the clock controller: DTR/CLK register in, reset/enable/status out.
interface prop_clk_ctrl_if;
  logic       dtr;
  logic [7:0] cfg;
  logic       nres;
  logic       clk_en;
  logic [2:0] mode;
  logic       switching;
  logic       cfg_err;

  modport master (output dtr, cfg, input nres, clk_en, mode, switching, cfg_err);
  modport slave  (input dtr, cfg, output nres, clk_en, mode, switching, cfg_err);
endinterface

// File: rtl/prop_pulse_stretch.sv
// DTR synchroniser and rising-edge detector plus the core reset pulse-length counter.
module prop_pulse_stretch #(
  parameter int RES_CYCLES = 2400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dtr_i,
  input  logic force_i,
  output logic restart_o,
  output logic done_o
);

  localparam int CW = $clog2(RES_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RES_CYCLES - 1);

  // [0],[1] form the synchroniser, [2] holds the previous synchronised level.
  logic [2:0]    dtr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  assign restart_o = (dtr_q[1] & ~dtr_q[2]) | force_i;
  assign done_o    = active_q && (cnt_q == CNT_LAST) && !restart_o;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (restart_o) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (done_o) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else begin
      dtr_q    <= {dtr_q[1:0], dtr_i};
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/prop_clk_ctrl.sv
// Core clock controller: reset sequencing, glitch-free clock-enable divisor switching
// with oscillator/PLL settle delay, and illegal-request detection.
module prop_clk_ctrl
  import prop_clk_pkg::*;
#(
  parameter int RES_CYCLES    = 2400,
  parameter int SETTLE_CYCLES = 1200,
  parameter int SLOW_DIV      = 600
) (
  input  logic           clk,
  input  logic           inp_resn,
  prop_clk_ctrl_if.slave bus
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  logic [7:0]       cfgx_q;
  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d, target_q, target_d;
  logic             pend_q, pend_d;
  logic [1:0]       ena_q, ena_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             clk_en_q, clk_en_d;
  logic             nres_q, switching_q;

  logic             restart, res_done;
  logic [2:0]       req;
  logic [1:0]       en_cur;
  logic [DIV_W-1:0] div;
  logic             tick, req_ok, mode_ok, rose, settled;
  logic             unused_cfg;

  prop_pulse_stretch #(.RES_CYCLES(RES_CYCLES)) u_res (
    .clk       (clk),
    .rst_n     (inp_resn),
    .dtr_i     (bus.dtr),
    .force_i   (cfgx_q[7]),
    .restart_o (restart),
    .done_o    (res_done)
  );

  assign req        = cfgx_q[2:0];
  assign en_cur     = cfgx_q[6:5];
  assign unused_cfg = ^cfgx_q[4:3];
  assign div        = sel_div(mode_q, DIV_W'(SLOW_DIV));
  assign tick       = (div_cnt_q == div - 1'b1);
  assign req_ok     = sel_legal(req, en_cur[0], en_cur[1]);
  assign mode_ok    = sel_legal(mode_q, en_cur[0], en_cur[1]);
  // ena_q holds the enables already covered by a settle period; any bit above it is new.
  assign rose       = |(en_cur & ~ena_q);
  assign settled    = (settle_cnt_q == SET_LAST);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    target_d     = target_q;
    pend_d       = pend_q;
    ena_d        = ena_q & en_cur;
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    settle_cnt_d = settle_cnt_q;
    cfg_err_d    = cfg_err_q;
    clk_en_d     = tick;
    if (restart) begin
      state_d      = ST_RESET;
      mode_d       = SEL_RCFAST;
      pend_d       = 1'b0;
      ena_d        = '0;
      div_cnt_d    = '0;
      settle_cnt_d = '0;
      clk_en_d     = 1'b1;
    end else begin
      case (state_q)
        ST_RESET: begin
          mode_d       = SEL_RCFAST;
          pend_d       = 1'b0;
          ena_d        = '0;
          div_cnt_d    = '0;
          settle_cnt_d = '0;
          clk_en_d     = 1'b1;
          if (res_done) state_d = ST_RUN;
        end
        ST_RUN, ST_SETTLE: begin
          if (!req_ok) cfg_err_d = 1'b1;
          if (!mode_ok) begin
            // The source in use lost its enable: fall back to RCFAST at the next pulse.
            cfg_err_d = 1'b1;
            pend_d    = 1'b0;
            if (tick) begin
              mode_d    = SEL_RCFAST;
              div_cnt_d = '0;
              state_d   = ST_RUN;
            end
          end else if (state_q == ST_RUN) begin
            if (req_ok && req != mode_q) begin
              target_d = req;
              if (rose) begin
                state_d      = ST_SETTLE;
                settle_cnt_d = '0;
                ena_d        = en_cur;
                pend_d       = 1'b0;
              end else begin
                pend_d = 1'b1;
              end
            end else if (req_ok) begin
              pend_d = 1'b0;
            end
            if (tick && pend_q) begin
              mode_d    = target_q;
              div_cnt_d = '0;
              pend_d    = 1'b0;
              state_d   = ST_RUN;
            end
          end else begin
            if (req_ok) target_d = req;
            if (rose) begin
              settle_cnt_d = '0;
              ena_d        = en_cur;
            end else if (!settled) begin
              settle_cnt_d = settle_cnt_q + 1'b1;
            end
            if (req_ok && req == mode_q) begin
              state_d = ST_RUN;
            end else if (!rose && settled && tick) begin
              mode_d    = target_q;
              div_cnt_d = '0;
              state_d   = ST_RUN;
            end
          end
        end
        default: state_d = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge inp_resn) begin
    if (!inp_resn) begin
      cfgx_q       <= '0;
      state_q      <= ST_RESET;
      mode_q       <= SEL_RCFAST;
      target_q     <= SEL_RCFAST;
      pend_q       <= 1'b0;
      ena_q        <= '0;
      div_cnt_q    <= '0;
      settle_cnt_q <= '0;
      cfg_err_q    <= 1'b0;
      clk_en_q     <= 1'b0;
      nres_q       <= 1'b0;
      switching_q  <= 1'b0;
    end else begin
      cfgx_q       <= bus.cfg;
      state_q      <= state_d;
      mode_q       <= mode_d;
      target_q     <= target_d;
      pend_q       <= pend_d;
      ena_q        <= ena_d;
      div_cnt_q    <= div_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      cfg_err_q    <= cfg_err_d;
      clk_en_q     <= clk_en_d;
      nres_q       <= (state_d != ST_RESET);
      switching_q  <= (state_d == ST_SETTLE);
    end
  end

  assign bus.nres      = nres_q;
  assign bus.clk_en    = clk_en_q;
  assign bus.mode      = mode_q;
  assign bus.switching = switching_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_prop_clk_ctrl.sv
// Directed bench for prop_clk_ctrl: reset timing, DTR reset, divisor switching, settle, error paths.
module tb_prop_clk_ctrl;

  logic clk = 1'b0;
  logic inp_resn;
  int   total = 0;
  int   bad   = 0;

  prop_clk_ctrl_if bus ();

  prop_clk_ctrl #(
    .RES_CYCLES    (2400),
    .SETTLE_CYCLES (1200),
    .SLOW_DIV      (600)
  ) dut (
    .clk      (clk),
    .inp_resn (inp_resn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    bit en_ok;
    inp_resn = 1'b0; bus.dtr = 1'b0; bus.cfg = 8'h00;
    step(3);
    total++; if (bus.nres !== 1'b0) begin bad++; $display("FAIL reset_nres got=%b want=0", bus.nres); end
    total++; if (bus.clk_en !== 1'b0) begin bad++; $display("FAIL reset_clk_en got=%b want=0", bus.clk_en); end
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL reset_mode got=%b want=000", bus.mode); end
    total++; if (bus.switching !== 1'b0) begin bad++; $display("FAIL reset_switching got=%b want=0", bus.switching); end
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b want=0", bus.cfg_err); end
    inp_resn = 1'b1;
    n = 0; en_ok = 1'b1;
    while (n < 2600) begin
      step(1); n++;
      if (bus.clk_en !== 1'b1) en_ok = 1'b0;
      if (bus.nres === 1'b1) break;
    end
    total++; if (n !== 2400) begin bad++; $display("FAIL reset_length got=%0d cycles want=2400", n); end
    total++; if (!en_ok) begin bad++; $display("FAIL reset_clk_en_cont got=gap want=continuous"); end
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL run_mode got=%b want=000", bus.mode); end
  endtask

  task automatic test_dtr();
    int n, low;
    step(5);
    bus.dtr = 1'b1;
    n = 0;
    do begin step(1); n++; end while (bus.nres !== 1'b0 && n < 3);
    total++; if (bus.nres !== 1'b0) begin bad++; $display("FAIL dtr_latency got nres=%b after %0d want=0", bus.nres, n); end
    low = 1;
    while (low < 2600) begin
      step(1);
      if (bus.nres === 1'b1) break;
      low++;
    end
    total++; if (low !== 2400) begin bad++; $display("FAIL dtr_length got=%0d want=2400", low); end
    bus.dtr = 1'b0;
    step(5);
    total++; if (bus.nres !== 1'b1) begin bad++; $display("FAIL dtr_fall got nres=%b want=1", bus.nres); end
  endtask

  task automatic test_slow();
    int n, gap;
    bus.cfg = 8'h01;
    n = 0;
    while (bus.mode !== 3'b001 && n < 10) begin step(1); n++; end
    total++; if (bus.mode !== 3'b001) begin bad++; $display("FAIL slow_mode got=%b want=001", bus.mode); end
    total++; if (bus.clk_en !== 1'b1) begin bad++; $display("FAIL slow_switch_pulse got=%b want=1", bus.clk_en); end
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      do begin step(1); gap++; end while (bus.clk_en !== 1'b1 && gap < 700);
      total++; if (gap !== 600) begin bad++; $display("FAIL slow_period%0d got=%0d want=600", p, gap); end
    end
    bus.cfg = 8'h00;
    n = 0;
    while (bus.mode !== 3'b000 && n < 700) begin step(1); n++; end
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL slow_back_mode got=%b want=000", bus.mode); end
    total++; if (bus.clk_en !== 1'b1) begin bad++; $display("FAIL slow_back_pulse got=%b want=1", bus.clk_en); end
    step(1);
    total++; if (bus.clk_en !== 1'b1) begin bad++; $display("FAIL fast_cont got=%b want=1", bus.clk_en); end
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL slow_cfg_err got=%b want=0", bus.cfg_err); end
  endtask

  task automatic test_settle();
    int n, hi;
    bit en_ok, mode_ok;
    bus.cfg = 8'h6F;
    n = 0;
    while (bus.switching !== 1'b1 && n < 5) begin step(1); n++; end
    total++; if (bus.switching !== 1'b1) begin bad++; $display("FAIL settle_enter got=%b want=1", bus.switching); end
    hi = 0; en_ok = 1'b1; mode_ok = 1'b1;
    while (bus.switching === 1'b1 && hi < 1300) begin
      if (bus.clk_en !== 1'b1) en_ok = 1'b0;
      if (bus.mode !== 3'b000) mode_ok = 1'b0;
      hi++;
      step(1);
    end
    total++; if (hi !== 1200) begin bad++; $display("FAIL settle_length got=%0d want=1200", hi); end
    total++; if (bus.mode !== 3'b111) begin bad++; $display("FAIL settle_mode got=%b want=111", bus.mode); end
    total++; if (bus.clk_en !== 1'b1) begin bad++; $display("FAIL settle_after_en got=%b want=1", bus.clk_en); end
    total++; if (!en_ok) begin bad++; $display("FAIL settle_old_clock got=gap want=continuous"); end
    total++; if (!mode_ok) begin bad++; $display("FAIL settle_mode_hold got=changed want=000"); end
  endtask

  task automatic test_back_to_back();
    int n, gap;
    bus.cfg = 8'h6D;
    n = 0;
    while (bus.mode !== 3'b101 && n < 5) begin step(1); n++; end
    total++; if (bus.mode !== 3'b101) begin bad++; $display("FAIL b2b_mode101 got=%b want=101", bus.mode); end
    total++; if (bus.switching !== 1'b0) begin bad++; $display("FAIL b2b_no_settle got=%b want=0", bus.switching); end
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      do begin step(1); gap++; end while (bus.clk_en !== 1'b1 && gap < 40);
      total++; if (gap !== 4) begin bad++; $display("FAIL b2b_div4_gap%0d got=%0d want=4", p, gap); end
    end
    bus.cfg = 8'h6A;
    n = 0;
    while (bus.mode !== 3'b010 && n < 10) begin step(1); n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_switch_point got=%0d want=4", n); end
    total++; if (bus.clk_en !== 1'b1) begin bad++; $display("FAIL b2b_switch_pulse got=%b want=1", bus.clk_en); end
    gap = 0;
    do begin step(1); gap++; end while (bus.clk_en !== 1'b1 && gap < 40);
    total++; if (gap !== 16) begin bad++; $display("FAIL b2b_div16_gap got=%0d want=16", gap); end
  endtask

  task automatic test_drop();
    int n;
    bus.cfg = 8'h42;
    n = 0;
    while (bus.mode !== 3'b000 && n < 20) begin step(1); n++; end
    total++; if (n !== 16) begin bad++; $display("FAIL drop_point got=%0d want=16", n); end
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL drop_mode got=%b want=000", bus.mode); end
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL drop_cfg_err got=%b want=1", bus.cfg_err); end
    step(20);
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL drop_stay got=%b want=000", bus.mode); end
  endtask

  task automatic test_reset_in_settle();
    int n;
    bus.cfg = 8'h6F;
    n = 0;
    while (bus.switching !== 1'b1 && n < 5) begin step(1); n++; end
    total++; if (bus.switching !== 1'b1) begin bad++; $display("FAIL rs_enter got=%b want=1", bus.switching); end
    step(100);
    bus.cfg = 8'hEF;
    n = 0;
    while (bus.nres !== 1'b0 && n < 3) begin step(1); n++; end
    total++; if (bus.nres !== 1'b0) begin bad++; $display("FAIL rs_nres got=%b want=0", bus.nres); end
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL rs_mode got=%b want=000", bus.mode); end
    total++; if (bus.switching !== 1'b0) begin bad++; $display("FAIL rs_switching got=%b want=0", bus.switching); end
    step(10);
    total++; if (bus.nres !== 1'b0) begin bad++; $display("FAIL rs_hold got=%b want=0", bus.nres); end
    bus.cfg = 8'h60;
    n = 0;
    while (bus.nres !== 1'b1 && n < 2500) begin step(1); n++; end
    total++; if (bus.nres !== 1'b1) begin bad++; $display("FAIL rs_release got=%b want=1", bus.nres); end
    step(1500);
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL rs_discard_mode got=%b want=000", bus.mode); end
    total++; if (bus.switching !== 1'b0) begin bad++; $display("FAIL rs_discard_sw got=%b want=0", bus.switching); end
  endtask

  task automatic test_illegal();
    int n;
    bus.cfg = 8'h00;
    inp_resn = 1'b0;
    step(2);
    inp_resn = 1'b1;
    n = 0;
    while (bus.nres !== 1'b1 && n < 2500) begin step(1); n++; end
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL ill_pre_err got=%b want=0", bus.cfg_err); end
    bus.cfg = 8'h04;
    step(3);
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b want=1", bus.cfg_err); end
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL ill_mode got=%b want=000", bus.mode); end
    step(30);
    total++; if (bus.mode !== 3'b000) begin bad++; $display("FAIL ill_mode_hold got=%b want=000", bus.mode); end
    total++; if (bus.switching !== 1'b0) begin bad++; $display("FAIL ill_switching got=%b want=0", bus.switching); end
    bus.cfg = 8'h00;
    step(5);
    total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b want=1", bus.cfg_err); end
    #2;
    inp_resn = 1'b0;
    #1;
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL ill_async_clear got=%b want=0", bus.cfg_err); end
    total++; if (bus.nres !== 1'b0) begin bad++; $display("FAIL ill_async_nres got=%b want=0", bus.nres); end
    step(2);
    inp_resn = 1'b1;
  endtask

  initial begin
    inp_resn = 1'b0;
    bus.dtr  = 1'b0;
    bus.cfg  = 8'h00;
    test_reset();
    test_dtr();
    test_slow();
    test_settle();
    test_back_to_back();
    test_drop();
    test_reset_in_settle();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
